core_mem_arbiter: RTL and testbench

Shares one single-ported synchronous memory between the core's instruction port (rom_*) and data port (ram_*). It sits between `Core` and a unified memory model and drives the core's `stall` input. When both ports request in the same cycle, it serializes the two accesses. It also holds each port's read data stable while the core is frozen.

---
 rtl/core_mem_arbiter_pkg.sv | 26 ++
 rtl/core_mem_arbiter_if.sv | 46 ++++
 rtl/arb_read_hold.sv | 24 ++
 rtl/core_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_core_mem_arbiter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/core_mem_arbiter_pkg.sv
// Shared widths, FSM states and grant encodings for the instruction/data memory arbiter.
package core_mem_arbiter_pkg;

    localparam int unsigned ADDR_BUS    = 32;
    localparam int unsigned DATA_BUS    = 32;
    localparam int unsigned MEM_SEL_BUS = 4;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_REPLAY = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_INST = 2'd1,
        GRANT_DATA = 2'd2
    } grant_e;

    typedef struct packed {
        logic                   en;
        logic [MEM_SEL_BUS-1:0] we;
        logic [ADDR_BUS-1:0]    addr;
        logic [DATA_BUS-1:0]    wdata;
    } mem_req_t;

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Core instruction/data ports, unified memory port, stall and conflict counter.
interface core_mem_arbiter_if;
    import core_mem_arbiter_pkg::*;

    logic                   rom_en;
    logic [MEM_SEL_BUS-1:0] rom_write_en;
    logic [ADDR_BUS-1:0]    rom_addr;
    logic [DATA_BUS-1:0]    rom_write_data;
    logic [DATA_BUS-1:0]    rom_read_data;

    logic                   ram_en;
    logic [MEM_SEL_BUS-1:0] ram_write_en;
    logic [ADDR_BUS-1:0]    ram_addr;
    logic [DATA_BUS-1:0]    ram_write_data;
    logic [DATA_BUS-1:0]    ram_read_data;

    logic                   mem_en;
    logic [MEM_SEL_BUS-1:0] mem_write_en;
    logic [ADDR_BUS-1:0]    mem_addr;
    logic [DATA_BUS-1:0]    mem_write_data;
    logic [DATA_BUS-1:0]    mem_read_data;

    logic                   stall;
    logic [31:0]            conflict_cnt;

    modport slave (
        input  rom_en, rom_write_en, rom_addr, rom_write_data,
        output rom_read_data,
        input  ram_en, ram_write_en, ram_addr, ram_write_data,
        output ram_read_data,
        output mem_en, mem_write_en, mem_addr, mem_write_data,
        input  mem_read_data,
        output stall, conflict_cnt
    );

    modport master (
        output rom_en, rom_write_en, rom_addr, rom_write_data,
        input  rom_read_data,
        output ram_en, ram_write_en, ram_addr, ram_write_data,
        input  ram_read_data,
        input  mem_en, mem_write_en, mem_addr, mem_write_data,
        output mem_read_data,
        input  stall, conflict_cnt
    );

endinterface

// File: rtl/arb_read_hold.sv
// Per-port read return: live memory data in the cycle after a read grant, held copy otherwise.
module arb_read_hold
    import core_mem_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_sel,
    input  logic [DATA_BUS-1:0] i_mem_data,
    output logic [DATA_BUS-1:0] o_read_data
);

    logic [DATA_BUS-1:0] r_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold <= '0;
        end else if (i_sel) begin
            r_hold <= i_mem_data;
        end
    end

    assign o_read_data = i_sel ? i_mem_data : r_hold;

endmodule

// File: rtl/core_mem_arbiter.sv
// Serializes core instruction and data accesses onto one single-ported synchronous memory.
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    core_mem_arbiter_if.slave   bus
);

    arb_state_e r_state;
    grant_e     r_last_grant;
    logic       r_last_rd;
    mem_req_t   r_pend;
    grant_e     r_pend_grant;
    logic [31:0] r_conflict_cnt;

    mem_req_t w_rom_req;
    mem_req_t w_ram_req;
    mem_req_t w_req;
    mem_req_t w_loser;
    grant_e   w_grant;
    grant_e   w_loser_grant;
    logic     w_conflict;
    logic     w_inst_sel;
    logic     w_data_sel;

    assign w_rom_req  = '{en: bus.rom_en, we: bus.rom_write_en, addr: bus.rom_addr, wdata: bus.rom_write_data};
    assign w_ram_req  = '{en: bus.ram_en, we: bus.ram_write_en, addr: bus.ram_addr, wdata: bus.ram_write_data};
    assign w_conflict = (r_state == ARB_IDLE) && bus.rom_en && bus.ram_en;

    always_comb begin
        w_req         = '0;
        w_grant       = GRANT_NONE;
        w_loser       = '0;
        w_loser_grant = GRANT_NONE;
        if (r_state == ARB_REPLAY) begin
            // Core still presents the already-accepted pair; only the pending request matters.
            w_req   = r_pend;
            w_grant = r_pend_grant;
        end else if (w_conflict) begin
            if (DATA_FIRST) begin
                w_req         = w_ram_req;
                w_grant       = GRANT_DATA;
                w_loser       = w_rom_req;
                w_loser_grant = GRANT_INST;
            end else begin
                w_req         = w_rom_req;
                w_grant       = GRANT_INST;
                w_loser       = w_ram_req;
                w_loser_grant = GRANT_DATA;
            end
        end else if (bus.ram_en) begin
            w_req   = w_ram_req;
            w_grant = GRANT_DATA;
        end else if (bus.rom_en) begin
            w_req   = w_rom_req;
            w_grant = GRANT_INST;
        end
    end

    // Gated by reset so memory and stall go quiet the instant reset asserts.
    assign bus.mem_en         = rst & w_req.en;
    assign bus.mem_write_en   = rst ? w_req.we    : '0;
    assign bus.mem_addr       = rst ? w_req.addr  : '0;
    assign bus.mem_write_data = rst ? w_req.wdata : '0;
    assign bus.stall          = rst & w_conflict;
    assign bus.conflict_cnt   = r_conflict_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ARB_IDLE;
            r_last_grant   <= GRANT_NONE;
            r_last_rd      <= 1'b0;
            r_pend         <= '0;
            r_pend_grant   <= GRANT_NONE;
            r_conflict_cnt <= '0;
        end else begin
            r_last_grant <= w_grant;
            r_last_rd    <= (w_req.we == '0);
            case (r_state)
                ARB_IDLE: begin
                    if (w_conflict) begin
                        r_pend       <= w_loser;
                        r_pend_grant <= w_loser_grant;
                        r_state      <= ARB_REPLAY;
                        if (r_conflict_cnt != '1) begin
                            r_conflict_cnt <= r_conflict_cnt + 32'd1;
                        end
                    end
                end
                ARB_REPLAY: begin
                    r_pend       <= '0;
                    r_pend_grant <= GRANT_NONE;
                    r_state      <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign w_inst_sel = (r_last_grant == GRANT_INST) && r_last_rd;
    assign w_data_sel = (r_last_grant == GRANT_DATA) && r_last_rd;

    arb_read_hold u_inst_hold (
        .clk         (clk),
        .rst         (rst),
        .i_sel       (w_inst_sel),
        .i_mem_data  (bus.mem_read_data),
        .o_read_data (bus.rom_read_data)
    );

    arb_read_hold u_data_hold (
        .clk         (clk),
        .rst         (rst),
        .i_sel       (w_data_sel),
        .i_mem_data  (bus.mem_read_data),
        .o_read_data (bus.ram_read_data)
    );

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter with a byte-writable synchronous memory model.
module tb_core_mem_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] mem [0:511];

    core_mem_arbiter_if bus();

    core_mem_arbiter #(.DATA_FIRST(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory reads return the cycle after the request.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_write_en == 4'b0000) begin
                bus.mem_read_data <= mem[bus.mem_addr[10:2]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_write_en[b]) mem[bus.mem_addr[10:2]][8*b +: 8] <= bus.mem_write_data[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        bus.rom_en = 1'b0; bus.rom_write_en = 4'b0; bus.rom_addr = '0; bus.rom_write_data = '0;
        bus.ram_en = 1'b0; bus.ram_write_en = 4'b0; bus.ram_addr = '0; bus.ram_write_data = '0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem[4]  = 32'h24010005;
        mem[8]  = 32'h8C220000;
        mem[9]  = 32'h00221820;
        mem[64] = 32'h12345678;
        mem[65] = 32'hDEADBEEF;
        bus.mem_read_data = '0;

        // Reset with both ports requesting
        idle_ports();
        rst = 1'b0;
        bus.rom_en = 1'b1; bus.rom_addr = 32'h20;
        bus.ram_en = 1'b1; bus.ram_addr = 32'h100;
        step();
        step();
        chk("rst_mem_en", bus.mem_en, 1'b0);
        chk("rst_mem_we", bus.mem_write_en, 4'b0);
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_cnt", bus.conflict_cnt, 32'h0);
        chk("rst_rom_rd", bus.rom_read_data, 32'h0);
        chk("rst_ram_rd", bus.ram_read_data, 32'h0);
        idle_ports();
        rst = 1'b1;
        step();

        // Single instruction read
        bus.rom_en = 1'b1; bus.rom_addr = 32'h10;
        #1;
        chk("single_mem_en", bus.mem_en, 1'b1);
        chk("single_mem_addr", bus.mem_addr, 32'h10);
        chk("single_stall", bus.stall, 1'b0);
        step();
        idle_ports();
        #1;
        chk("single_rom_live", bus.rom_read_data, 32'h24010005);
        chk("single_idle_mem_en", bus.mem_en, 1'b0);
        step();
        chk("single_rom_held", bus.rom_read_data, 32'h24010005);

        // Read/read conflict, data first
        bus.rom_en = 1'b1; bus.rom_addr = 32'h20;
        bus.ram_en = 1'b1; bus.ram_addr = 32'h100;
        #1;
        chk("cf_c0_addr", bus.mem_addr, 32'h100);
        chk("cf_c0_stall", bus.stall, 1'b1);
        step();
        bus.rom_addr = 32'h30;
        bus.ram_addr = 32'h1F0;
        #1;
        chk("cf_c1_addr", bus.mem_addr, 32'h20);
        chk("cf_c1_mem_en", bus.mem_en, 1'b1);
        chk("cf_c1_stall", bus.stall, 1'b0);
        chk("cf_c1_ram_rd", bus.ram_read_data, 32'h12345678);
        chk("cf_c1_rom_stable", bus.rom_read_data, 32'h24010005);
        step();
        idle_ports();
        #1;
        chk("cf_c2_rom_rd", bus.rom_read_data, 32'h8C220000);
        chk("cf_c2_ram_held", bus.ram_read_data, 32'h12345678);
        chk("cf_c2_mem_en", bus.mem_en, 1'b0);
        chk("cf_cnt1", bus.conflict_cnt, 32'd1);

        // Conflict with a partial data write
        step();
        bus.rom_en = 1'b1; bus.rom_addr = 32'h24;
        bus.ram_en = 1'b1; bus.ram_addr = 32'h104;
        bus.ram_write_en = 4'b0011; bus.ram_write_data = 32'hAAAA5555;
        #1;
        chk("wr_c0_addr", bus.mem_addr, 32'h104);
        chk("wr_c0_we", bus.mem_write_en, 4'b0011);
        chk("wr_c0_wdata", bus.mem_write_data, 32'hAAAA5555);
        chk("wr_c0_stall", bus.stall, 1'b1);
        step();
        chk("wr_c1_addr", bus.mem_addr, 32'h24);
        chk("wr_c1_we", bus.mem_write_en, 4'b0);
        chk("wr_c1_ram_held", bus.ram_read_data, 32'h12345678);
        step();
        idle_ports();
        #1;
        chk("wr_c2_rom_rd", bus.rom_read_data, 32'h00221820);
        chk("wr_c2_ram_held", bus.ram_read_data, 32'h12345678);
        chk("wr_mem_word", mem[65], 32'hDEAD5555);
        chk("wr_cnt2", bus.conflict_cnt, 32'd2);

        // Reset asserted during REPLAY
        step();
        bus.rom_en = 1'b1; bus.rom_addr = 32'h10;
        bus.ram_en = 1'b1; bus.ram_addr = 32'h100;
        step();
        chk("rr_replay_addr", bus.mem_addr, 32'h10);
        rst = 1'b0;
        #1;
        chk("rr_mem_en", bus.mem_en, 1'b0);
        chk("rr_stall", bus.stall, 1'b0);
        chk("rr_cnt", bus.conflict_cnt, 32'h0);
        chk("rr_rom_rd", bus.rom_read_data, 32'h0);
        step();
        idle_ports();
        rst = 1'b1;
        #1;
        chk("rr_post_mem_en0", bus.mem_en, 1'b0);
        step();
        chk("rr_post_mem_en1", bus.mem_en, 1'b0);
        bus.rom_en = 1'b1; bus.rom_addr = 32'h20;
        bus.ram_en = 1'b1; bus.ram_addr = 32'h100;
        #1;
        chk("rr_idle_stall", bus.stall, 1'b1);
        step();
        step();
        idle_ports();
        #1;
        chk("rr_cnt1", bus.conflict_cnt, 32'd1);

        // Counter saturation
        step();
        force dut.r_conflict_cnt = 32'hFFFFFFFE;
        bus.rom_en = 1'b1; bus.rom_addr = 32'h20;
        bus.ram_en = 1'b1; bus.ram_addr = 32'h100;
        step();
        release dut.r_conflict_cnt;
        step();
        step();
        step();
        step();
        step();
        idle_ports();
        #1;
        chk("sat_cnt", bus.conflict_cnt, 32'hFFFFFFFF);
        chk("sat_stall", bus.stall, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
